hawk_att_lookup: RTL and testbench
==================================

# hawk_att_lookup

Translation front-end of the HACD pipeline. It accepts a CPU host-page lookup (`att_lkup_reqpkt_t`) and fetches the 64-byte ATT cache line holding that page's `AttEntry` over the AXI read master interface (`axi_rd_reqpkt_t` / `axi_rd_resppkt_t`). It then decodes the entry and hands a `trnsl_reqpkt_t` to the downstream translation/override stage. The block sits between the CPU request decoder and the AXI read master, which it shares with the page-read manager through an external arbiter.

## Interface
- `ATT_BASE`, default `HAWK_ATT_START`: byte address of ATT entry 0.
- `HPPA_BASE`, default `HPPA_BASE_ADDR`: host physical base; its bits [ADDR_W-1:12] map to ATT index 0.
- `ENTRY_CNT`, default `ATT_ENTRY_CNT`: number of valid ATT entries.
- Note: ADDR_W = `` `HACD_AXI4_ADDR_WIDTH `` (64).

Ports (the clock is a single clock; reset is asynchronous and active-low):
- `clk_i`  in  1  block clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `lkup_req_i`  in  `att_lkup_reqpkt_t`  `.lookup` is valid; also carries `.hppa` and `.zeroBlkWr`.
- `lkup_rdy_o`  out  1  request accepted when `lookup & lkup_rdy_o`.
- `rd_req_o`  out  `axi_rd_reqpkt_t`  AR channel (addr, arlen, arvalid) plus rready.
- `rd_rdy_i`  in  `axi_rd_rdypkt_t`  arready.
- `rd_resp_i`  in  `axi_rd_resppkt_t`  R channel.
- `trnsl_o`  out  `trnsl_reqpkt_t`  decoded translation.
- `trnsl_vld_o`  out  1  `trnsl_o` valid.
- `trnsl_rdy_i`  in  1  downstream accept.
- `lkup_err_o`  out  1  qualifies `trnsl_o` as an error (index out of range or AXI SLVERR/DECERR).
- `inv_i`  in  1  ATT line-cache invalidate (used only with the macro).

## Operation
- FSM states: IDLE, AR, R, RESP. `lkup_rdy_o` = (state==IDLE).
- Index computation on accept: idx = hppa − HPPA_BASE[ADDR_W-1:12], unsigned, ADDR_W-12 bits.
- Out-of-range request (idx ≥ ENTRY_CNT):
  - The FSM goes IDLE→RESP with no AXI read.
  - `lkup_err_o`=1, `allow_access`=0, `ppa`=0, `sts`=0, `zpd_update`=0.
- In-range request:
  - Line address = ATT_BASE + {idx[ADDR_W-13:3], 6'b0}.
  - Slot = idx[2:0].
  - `arlen`=0 (single 512-bit beat). State goes to AR.
- AR: `arvalid`=1. On `arready`, go to R.
- R: `rready`=1. On `rvalid & rlast`, capture `get_8byte_byteswap(rdata)` and go to RESP.
  - A `rvalid` without `rlast` is ignored.
  - `rresp[1]`=1 sets the error flag, and outputs are then as for out-of-range.
- Entry decode (e = swapped line [64*slot +: 64], cast to `AttEntry`):
  - `ppa` = {e.way[ADDR_W-11:2], 12'h0}.
  - `sts` = e.sts.
  - `allow_access` = 1 for STS_UNCOMP or STS_INCOMP; 0 for STS_DALLOC or STS_COMP.
  - `zpd_update` = zeroBlkWr & (sts==STS_UNCOMP).
  - `zpd_cnt` = e.zpd_cnt+1, saturating at 8'hFF; it equals e.zpd_cnt when `zpd_update`=0.
- RESP: `trnsl_vld_o`=1. Output is held stable until `trnsl_rdy_i`, then the FSM returns to IDLE.
- Only one lookup is in flight at a time; there is no request queue.

## Timing
- Reset values: state IDLE; `lkup_rdy_o`=1; `trnsl_vld_o`=0; `lkup_err_o`=0; `rd_req_o`=0 (arvalid=0, rready=0, addr=0, arlen=0); `trnsl_o`=0.
- All outputs are registered except `lkup_rdy_o`, which is a decode of state.
- Minimum latency with zero-wait AXI:
  - Accept at edge 0; arvalid high in cycle 1.
  - arready in cycle 1; rready high in cycle 2.
  - rvalid/rlast in cycle 2; `trnsl_vld_o` high in cycle 3.
- Error path, and cache hit: `trnsl_vld_o` is high in the cycle after accept.
- A new request can be accepted in the cycle after the `trnsl_rdy_i` handshake. There is no back-to-back accept in the handshake cycle.
- Reset asserted mid-transaction: the FSM aborts to IDLE immediately and arvalid/rready drop asynchronously. Any in-flight R beat is the arbiter's responsibility to drain.
- `arvalid` and `addr` stay stable until `arready`, per AXI.

## Configuration
- Macro: `HAWK_ATT_LKUP_CACHE_EN`.
- Defined:
  - A single-line cache holds the last fetched swapped 512-bit line and its line index.
  - A valid in-range request whose idx[ADDR_W-13:3] matches the tag goes IDLE→RESP without AXI traffic.
  - `inv_i` clears the valid bit; if asserted in the same cycle as an R capture, the invalidate wins.
  - The line is not cached on error.
- Undefined: every in-range lookup issues an AXI read; `inv_i` is ignored.

## Test plan
- Setup for all scenarios: HPPA_BASE=0xFFF6400000, ATT_BASE=0xFFF6100000, ENTRY_CNT=16.
- hppa=0xFFF6403, zero-wait AXI, slot 3 = 64'h000000003FFD8C15:
  - araddr=0xFFF6100000 and arlen=0.
  - `trnsl_vld_o` in cycle 3 with ppa=0xFFF6305000, sts=01, allow_access=1.
- hppa=0xFFF6409 with zeroBlkWr=1, slot 1 entry UNCOMP with zpd_cnt=0xFF:
  - araddr=0xFFF6100040.
  - zpd_update=1, zpd_cnt=0xFF (saturated).
- hppa=0xFFF6410 (idx 16): no arvalid; next cycle `lkup_err_o`=1, allow_access=0.
- Entry sts=STS_COMP, rresp=0:
  - allow_access=0, sts=10.
  - Hold `trnsl_rdy_i`=0 for 5 cycles: outputs stable and `lkup_rdy_o`=0 throughout.
- arready delayed 4 cycles, then rresp=2'b10: araddr stable until the handshake; `lkup_err_o`=1.
- With the macro defined:
  - Lookups idx 3 then idx 5: the second completes with no arvalid, 1 cycle after accept.
  - After `inv_i`, idx 5 again issues a read.

Source files
------------

// File: rtl/hawk_att_lookup_if.sv
// Shared types for the HACD ATT lookup front-end, and the bus interface that bundles
// the lookup request, AXI read and translation output channels of hawk_att_lookup.
package hawk_att_pkg;

  localparam int ADDR_W = 64;
  localparam int IDX_W  = ADDR_W - 12;

  localparam logic [ADDR_W-1:0] HAWK_ATT_START = 64'h0000_00FF_F610_0000;
  localparam logic [ADDR_W-1:0] HPPA_BASE_ADDR = 64'h0000_00FF_F640_0000;
  localparam int unsigned       ATT_ENTRY_CNT  = 16;

  typedef enum logic [1:0] {
    STS_DALLOC = 2'b00,
    STS_UNCOMP = 2'b01,
    STS_COMP   = 2'b10,
    STS_INCOMP = 2'b11
  } att_sts_e;

  typedef struct packed {
    logic [7:0]        zpd_cnt;
    logic [ADDR_W-9:2] way;
    att_sts_e          sts;
  } AttEntry;

  typedef struct packed {
    logic             lookup;
    logic [IDX_W-1:0] hppa;
    logic             zeroBlkWr;
  } att_lkup_reqpkt_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        arlen;
    logic              arvalid;
    logic              rready;
  } axi_rd_reqpkt_t;

  typedef struct packed {
    logic arready;
  } axi_rd_rdypkt_t;

  typedef struct packed {
    logic [511:0] rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
  } axi_rd_resppkt_t;

  typedef struct packed {
    logic              allow_access;
    logic [ADDR_W-1:0] ppa;
    att_sts_e          sts;
    logic              zpd_update;
    logic [7:0]        zpd_cnt;
  } trnsl_reqpkt_t;

  // ATT lines are stored big-endian per 8-byte entry.
  function automatic logic [511:0] get_8byte_byteswap(input logic [511:0] d);
    logic [511:0] r;
    for (int w = 0; w < 8; w++) begin
      for (int b = 0; b < 8; b++) begin
        r[64*w + 8*b +: 8] = d[64*w + 8*(7-b) +: 8];
      end
    end
    return r;
  endfunction

endpackage

interface hawk_att_lookup_if;
  import hawk_att_pkg::*;

  att_lkup_reqpkt_t lkup_req;
  logic             lkup_rdy;
  axi_rd_reqpkt_t   rd_req;
  axi_rd_rdypkt_t   rd_rdy;
  axi_rd_resppkt_t  rd_resp;
  trnsl_reqpkt_t    trnsl;
  logic             trnsl_vld;
  logic             trnsl_rdy;
  logic             lkup_err;
  logic             inv;

  modport slave (
    input  lkup_req, rd_rdy, rd_resp, trnsl_rdy, inv,
    output lkup_rdy, rd_req, trnsl, trnsl_vld, lkup_err
  );

  modport master (
    output lkup_req, rd_rdy, rd_resp, trnsl_rdy, inv,
    input  lkup_rdy, rd_req, trnsl, trnsl_vld, lkup_err
  );

endinterface

// File: rtl/hawk_att_lookup.sv
// ATT lookup: maps a host page to its AttEntry via one 64-byte AXI line read and decodes it.
// Optional single-line ATT cache enabled by defining HAWK_ATT_LKUP_CACHE_EN.
module hawk_att_lookup
  import hawk_att_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ATT_BASE  = HAWK_ATT_START,
  parameter logic [ADDR_W-1:0] HPPA_BASE = HPPA_BASE_ADDR,
  parameter int unsigned       ENTRY_CNT = ATT_ENTRY_CNT
) (
  input logic              clk_i,
  input logic              rst_ni,
  hawk_att_lookup_if.slave bus
);

  typedef enum logic [1:0] {IDLE, AR, R, RESP} state_e;

  state_e         state;
  axi_rd_reqpkt_t rd_req_q;
  trnsl_reqpkt_t  trnsl_q;
  logic           trnsl_vld_q;
  logic           lkup_err_q;
  logic           zero_blk_q;
  logic [2:0]     slot_q;

  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              accept;
  logic              r_last_beat;
  logic              hit;
  logic [ADDR_W-1:0] line_addr;
  logic [511:0]      r_line;
  logic [511:0]      cache_line;
  logic              unused_ok;

  assign idx         = bus.lkup_req.hppa - HPPA_BASE[ADDR_W-1:12];
  assign in_range    = idx < IDX_W'(ENTRY_CNT);
  assign accept      = bus.lkup_req.lookup && (state == IDLE);
  assign line_addr   = ATT_BASE + ADDR_W'({idx[IDX_W-1:3], 6'b0});
  assign r_last_beat = (state == R) && bus.rd_resp.rvalid && bus.rd_resp.rlast;
  assign r_line      = get_8byte_byteswap(bus.rd_resp.rdata);

  function automatic trnsl_reqpkt_t decode_entry(input logic [511:0] line,
                                                 input logic [2:0]   slot,
                                                 input logic         zero_blk);
    AttEntry       e;
    trnsl_reqpkt_t t;
    e              = AttEntry'(line[64*slot +: 64]);
    t              = '0;
    t.ppa          = {e.way[ADDR_W-11:2], 12'h0};
    t.sts          = e.sts;
    t.allow_access = (e.sts == STS_UNCOMP) || (e.sts == STS_INCOMP);
    t.zpd_update   = zero_blk && (e.sts == STS_UNCOMP);
    t.zpd_cnt      = (t.zpd_update && (e.zpd_cnt != 8'hFF)) ? e.zpd_cnt + 8'd1 : e.zpd_cnt;
    return t;
  endfunction

`ifdef HAWK_ATT_LKUP_CACHE_EN
  localparam int TAG_W = IDX_W - 3;

  logic             cache_vld;
  logic [TAG_W-1:0] cache_tag;
  logic [TAG_W-1:0] pend_tag;

  assign hit = cache_vld && (cache_tag == idx[IDX_W-1:3]);

  // An invalidate in the capture cycle must win over the fill.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cache_vld <= 1'b0;
      cache_tag <= '0;
      pend_tag  <= '0;
    end else begin
      if (accept) pend_tag <= idx[IDX_W-1:3];
      if (bus.inv) begin
        cache_vld <= 1'b0;
      end else if (r_last_beat && !bus.rd_resp.rresp[1]) begin
        cache_vld <= 1'b1;
        cache_tag <= pend_tag;
      end
    end
  end

  // NOTE: the line store is pure data qualified by cache_vld, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (r_last_beat && !bus.rd_resp.rresp[1]) cache_line <= r_line;
  end

  assign unused_ok = bus.rd_resp.rresp[0];
`else
  assign hit        = 1'b0;
  assign cache_line = '0;
  assign unused_ok  = ^{bus.rd_resp.rresp[0], bus.inv};
`endif

  // NOTE: state and registered outputs use non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      rd_req_q    <= '0;
      trnsl_q     <= '0;
      trnsl_vld_q <= 1'b0;
      lkup_err_q  <= 1'b0;
      slot_q      <= '0;
      zero_blk_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            slot_q     <= idx[2:0];
            zero_blk_q <= bus.lkup_req.zeroBlkWr;
            if (!in_range) begin
              trnsl_q     <= '0;
              lkup_err_q  <= 1'b1;
              trnsl_vld_q <= 1'b1;
              state       <= RESP;
            end else if (hit) begin
              trnsl_q     <= decode_entry(cache_line, idx[2:0], bus.lkup_req.zeroBlkWr);
              lkup_err_q  <= 1'b0;
              trnsl_vld_q <= 1'b1;
              state       <= RESP;
            end else begin
              rd_req_q.addr    <= line_addr;
              rd_req_q.arlen   <= 8'd0;
              rd_req_q.arvalid <= 1'b1;
              state            <= AR;
            end
          end
        end
        AR: begin
          if (bus.rd_rdy.arready) begin
            rd_req_q.arvalid <= 1'b0;
            rd_req_q.rready  <= 1'b1;
            state            <= R;
          end
        end
        R: begin
          // Beats without rlast are dropped; only the final beat carries the line.
          if (bus.rd_resp.rvalid && bus.rd_resp.rlast) begin
            rd_req_q.rready <= 1'b0;
            if (bus.rd_resp.rresp[1]) begin
              trnsl_q    <= '0;
              lkup_err_q <= 1'b1;
            end else begin
              trnsl_q    <= decode_entry(r_line, slot_q, zero_blk_q);
              lkup_err_q <= 1'b0;
            end
            trnsl_vld_q <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (bus.trnsl_rdy) begin
            trnsl_vld_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.lkup_rdy  = (state == IDLE);
  assign bus.rd_req    = rd_req_q;
  assign bus.trnsl     = trnsl_q;
  assign bus.trnsl_vld = trnsl_vld_q;
  assign bus.lkup_err  = lkup_err_q;

endmodule

// File: tb/tb_hawk_att_lookup.sv
// Self-checking bench for hawk_att_lookup: directed test-plan cases plus randomized lookups
// against a transaction-level model of the ATT table, AXI slave and optional line cache.
module tb_hawk_att_lookup;
  import hawk_att_pkg::*;

  localparam logic [63:0] ATT_B  = 64'h0000_00FF_F610_0000;
  localparam logic [63:0] HPPA_B = 64'h0000_00FF_F640_0000;
  localparam logic [51:0] PAGE0  = 52'hFFF6400;
`ifdef HAWK_ATT_LKUP_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hawk_att_lookup_if bus ();

  hawk_att_lookup #(
    .ATT_BASE  (ATT_B),
    .HPPA_BASE (HPPA_B),
    .ENTRY_CNT (16)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model state
  logic [63:0]   att_mem [16];
  logic          c_valid = 1'b0;
  logic [63:0]   c_tag   = '0;
  logic [63:0]   c_line  [8];
  logic          exp_axi, exp_err, in_flight = 1'b0;
  logic [63:0]   exp_addr;
  int            exp_delta;
  trnsl_reqpkt_t exp_trnsl;

  // Responder configuration and observation
  int            ar_wait = 0, r_wait = 0, edge_cnt = 0, acc_edge = 0, seen_delta = 0;
  bit            junk = 1'b0;
  logic [1:0]    rresp_cfg = 2'b00;
  logic          vld_seen = 1'b0, ar_seen = 1'b0, seen_err;
  logic [63:0]   seen_addr;
  trnsl_reqpkt_t seen_trnsl;

  function automatic trnsl_reqpkt_t model_decode(input logic [63:0] e, input logic zbw);
    trnsl_reqpkt_t t;
    logic [1:0]    s;
    int            cnt;
    s              = e[1:0];
    t              = '0;
    t.ppa          = ((e >> 2) & 64'h000F_FFFF_FFFF_FFFF) << 12;
    t.sts          = att_sts_e'(s);
    t.allow_access = (s == STS_UNCOMP) || (s == STS_INCOMP);
    t.zpd_update   = zbw && (s == STS_UNCOMP);
    cnt            = int'(e >> 56);
    if (t.zpd_update) cnt = (cnt + 1 > 255) ? 255 : cnt + 1;
    t.zpd_cnt      = 8'(cnt);
    return t;
  endfunction

  function automatic logic [511:0] build_line(input int ln);
    logic [511:0] l;
    logic [63:0]  e, sw;
    for (int w = 0; w < 8; w++) begin
      e  = (ln * 8 + w < 16) ? att_mem[ln * 8 + w] : 64'hBAD0_BAD0_BAD0_BAD0;
      sw = {<<8{e}};
      l[64*w +: 64] = sw;
    end
    return l;
  endfunction

  task automatic model_expect(input logic [51:0] idx, input logic zbw, input logic [1:0] rr,
                              input int a, input int r, input bit jb);
    logic [63:0] idx64, ln;
    logic        in_rng, hit;
    int          slot;
    idx64    = 64'(idx);
    ln       = idx64 >> 3;
    slot     = int'(idx64 % 8);
    in_rng   = idx64 < 16;
    hit      = CACHE_EN && c_valid && (c_tag == ln) && in_rng;
    exp_addr = ATT_B + (ln << 6);
    exp_axi  = in_rng && !hit;
    exp_delta = exp_axi ? 2 + a + r + int'(jb) : 0;
    if (!in_rng || (exp_axi && rr[1])) begin
      exp_err   = 1'b1;
      exp_trnsl = '0;
    end else begin
      exp_err   = 1'b0;
      exp_trnsl = model_decode(hit ? c_line[slot] : att_mem[int'(idx64)], zbw);
      if (!hit) begin
        c_valid = 1'b1;
        c_tag   = ln;
        for (int k = 0; k < 8; k++) c_line[k] = att_mem[int'(ln) * 8 + k];
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  // AXI read slave: configurable AR wait, R wait, optional non-last beat, response code.
  initial begin
    bus.rd_rdy  = '0;
    bus.rd_resp = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.rd_req.arvalid) begin
        int          a, r;
        bit          jb;
        logic [1:0]  rr;
        logic [63:0] addr;
        a = ar_wait; r = r_wait; jb = junk; rr = rresp_cfg; addr = bus.rd_req.addr;
        repeat (a) @(negedge clk);
        bus.rd_rdy.arready = 1'b1;
        @(negedge clk);
        bus.rd_rdy.arready = 1'b0;
        repeat (r) @(negedge clk);
        if (jb) begin
          bus.rd_resp.rvalid = 1'b1;
          bus.rd_resp.rlast  = 1'b0;
          bus.rd_resp.rresp  = 2'b00;
          bus.rd_resp.rdata  = {16{$urandom}};
          @(negedge clk);
        end
        bus.rd_resp.rvalid = 1'b1;
        bus.rd_resp.rlast  = 1'b1;
        bus.rd_resp.rresp  = rr;
        bus.rd_resp.rdata  = build_line(int'((addr - ATT_B) >> 6));
        @(negedge clk);
        bus.rd_resp.rvalid = 1'b0;
        bus.rd_resp.rlast  = 1'b0;
      end
    end
  end

  // Compare process: AR channel and translation output against the model, every cycle.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (bus.rd_req.arvalid) begin
        check("arvalid_allowed", exp_axi && in_flight, 1);
        check("araddr", bus.rd_req.addr, exp_addr);
        check("arlen", bus.rd_req.arlen, 0);
        if (!ar_seen) begin
          ar_seen   = 1'b1;
          seen_addr = bus.rd_req.addr;
        end
      end
      if (bus.trnsl_vld) begin
        check("vld_in_flight", in_flight, 1);
        check("rdy_low_in_resp", bus.lkup_rdy, 0);
        if (!vld_seen) begin
          vld_seen   = 1'b1;
          seen_delta = edge_cnt - acc_edge;
          seen_trnsl = bus.trnsl;
          seen_err   = bus.lkup_err;
          check("latency", seen_delta, exp_delta);
          check("lkup_err", bus.lkup_err, exp_err);
          check("ppa", bus.trnsl.ppa, exp_trnsl.ppa);
          check("sts", bus.trnsl.sts, exp_trnsl.sts);
          check("allow_access", bus.trnsl.allow_access, exp_trnsl.allow_access);
          check("zpd_update", bus.trnsl.zpd_update, exp_trnsl.zpd_update);
          check("zpd_cnt", bus.trnsl.zpd_cnt, exp_trnsl.zpd_cnt);
        end else begin
          check("hold_ppa", bus.trnsl.ppa, seen_trnsl.ppa);
          check("hold_fields", {bus.trnsl.sts, bus.trnsl.allow_access, bus.trnsl.zpd_update,
                                bus.trnsl.zpd_cnt},
                {seen_trnsl.sts, seen_trnsl.allow_access, seen_trnsl.zpd_update,
                 seen_trnsl.zpd_cnt});
          check("hold_err", bus.lkup_err, seen_err);
        end
      end
    end
  end

  task automatic reset_dut();
    rst_n = 1'b0;
    in_flight = 1'b0;
    c_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_inv();
    @(negedge clk);
    bus.inv = 1'b1;
    @(negedge clk);
    bus.inv = 1'b0;
    c_valid = 1'b0;
  endtask

  task automatic run_lookup(input logic [51:0] hppa, input logic zbw, input int a, input int r,
                            input bit jb, input logic [1:0] rr, input int hold);
    int t;
    ar_wait = a; r_wait = r; junk = jb; rresp_cfg = rr;
    @(negedge clk);
    bus.lkup_req.hppa      = hppa;
    bus.lkup_req.zeroBlkWr = zbw;
    bus.lkup_req.lookup    = 1'b1;
    t = 0;
    while (!bus.lkup_rdy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.lkup_rdy) begin
      check("accept_timeout", 0, 1);
      bus.lkup_req.lookup = 1'b0;
      reset_dut();
      return;
    end
    model_expect(hppa - PAGE0, zbw, rr, a, r, jb);
    vld_seen  = 1'b0;
    ar_seen   = 1'b0;
    in_flight = 1'b1;
    acc_edge  = edge_cnt + 1;
    @(posedge clk);
    #1;
    bus.lkup_req.lookup = 1'b0;
    bus.lkup_req.hppa   = 52'($urandom);
    t = 0;
    while (!vld_seen && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!vld_seen) begin
      check("trnsl_timeout", 0, 1);
      reset_dut();
      return;
    end
    repeat (hold) @(negedge clk);
    bus.trnsl_rdy = 1'b1;
    @(posedge clk);
    #1;
    bus.trnsl_rdy = 1'b0;
    in_flight = 1'b0;
    @(negedge clk);
    check("vld_drop_after_hs", bus.trnsl_vld, 0);
    check("rdy_after_hs", bus.lkup_rdy, 1);
  endtask

  initial begin
    bus.lkup_req  = '0;
    bus.trnsl_rdy = 1'b0;
    bus.inv       = 1'b0;
    for (int i = 0; i < 16; i++) att_mem[i] = {$urandom, $urandom};
    repeat (2) @(negedge clk);
    check("rst_lkup_rdy", bus.lkup_rdy, 1);
    check("rst_trnsl_vld", bus.trnsl_vld, 0);
    check("rst_lkup_err", bus.lkup_err, 0);
    check("rst_arvalid_rready", {bus.rd_req.arvalid, bus.rd_req.rready}, 0);
    check("rst_addr_arlen", bus.rd_req.addr | 64'(bus.rd_req.arlen), 0);
    check("rst_ppa", bus.trnsl.ppa, 0);
    rst_n = 1'b1;

    // Zero-wait fetch of slot 3
    att_mem[3] = 64'h0000_0000_3FFD_8C15;
    run_lookup(52'hFFF6403, 1'b0, 0, 0, 1'b0, 2'b00, 0);
    check("t1_araddr", seen_addr, 64'hFF_F610_0000);
    check("t1_cycle", seen_delta, 2);
    check("t1_ppa", seen_trnsl.ppa, 64'hFF_F630_5000);
    check("t1_sts", seen_trnsl.sts, 2'b01);
    check("t1_allow", seen_trnsl.allow_access, 1);

    // Saturating zero-page counter in line 1
    att_mem[9] = 64'hFF00_0000_1234_5671;
    run_lookup(52'hFFF6409, 1'b1, 0, 0, 1'b0, 2'b00, 0);
    check("t2_araddr", seen_addr, 64'hFF_F610_0040);
    check("t2_zpd_update", seen_trnsl.zpd_update, 1);
    check("t2_zpd_cnt", seen_trnsl.zpd_cnt, 8'hFF);

    // First out-of-range index
    run_lookup(52'hFFF6410, 1'b0, 0, 0, 1'b0, 2'b00, 0);
    check("t3_no_ar", ar_seen, 0);
    check("t3_cycle", seen_delta, 0);
    check("t3_err", seen_err, 1);
    check("t3_allow", seen_trnsl.allow_access, 0);

    // Compressed entry held under back-pressure
    att_mem[5] = 64'h0500_0000_0ABC_DEF2;
    do_inv();
    run_lookup(52'hFFF6405, 1'b1, 0, 0, 1'b0, 2'b00, 5);
    check("t4_allow", seen_trnsl.allow_access, 0);
    check("t4_sts", seen_trnsl.sts, 2'b10);

    // Slow arready then SLVERR
    do_inv();
    run_lookup(52'hFFF640A, 1'b0, 4, 0, 1'b0, 2'b10, 2);
    check("t5_araddr", seen_addr, 64'hFF_F610_0040);
    check("t5_cycle", seen_delta, 6);
    check("t5_err", seen_err, 1);

    // Asynchronous reset while arvalid is pending
    ar_wait = 6; r_wait = 0; junk = 1'b0;
    @(negedge clk);
    exp_axi = 1'b1; exp_addr = ATT_B; in_flight = 1'b1;
    bus.lkup_req.hppa = 52'hFFF6404; bus.lkup_req.lookup = 1'b1;
    @(posedge clk);
    #1;
    bus.lkup_req.lookup = 1'b0;
    @(negedge clk);
    #2;
    check("t6_ar_before_rst", bus.rd_req.arvalid, 1);
    rst_n = 1'b0;
    #1;
    check("t6_ar_drop", bus.rd_req.arvalid, 0);
    check("t6_rdy_after_rst", bus.lkup_rdy, 1);
    in_flight = 1'b0;
    c_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);

`ifdef HAWK_ATT_LKUP_CACHE_EN
    do_inv();
    run_lookup(52'hFFF6403, 1'b0, 0, 0, 1'b0, 2'b00, 0);
    run_lookup(52'hFFF6405, 1'b0, 0, 0, 1'b0, 2'b00, 0);
    check("c1_hit_no_ar", ar_seen, 0);
    check("c1_hit_cycle", seen_delta, 0);
    do_inv();
    run_lookup(52'hFFF6405, 1'b0, 0, 0, 1'b0, 2'b00, 0);
    check("c2_refetch_ar", ar_seen, 1);
    check("c2_refetch_cycle", seen_delta, 2);
`endif

    // Randomized lookups
    for (int n = 0; n < 60; n++) begin
      logic [51:0] hp;
      logic [1:0]  rr;
      int          sel;
      for (int i = 0; i < 16; i++) begin
        att_mem[i] = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) att_mem[i][63:56] = 8'hFF;
      end
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      hp = PAGE0 - 52'd1;
      else if (sel == 1) hp = PAGE0 + 52'($urandom_range(16, 19));
      else               hp = PAGE0 + 52'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0:       rr = 2'b10;
        1:       rr = 2'b11;
        2:       rr = 2'b01;
        default: rr = 2'b00;
      endcase
      if ($urandom_range(0, 4) == 0) do_inv();
      run_lookup(hp, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0), rr,
                 int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
